// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and a width helper
// used to size the grant index and hold counter.
package fsm_arb_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01,
      ST_GAP   = 2'b10
   } arb_state_t;

   // Never returns less than 1 so single-value ranges still get a real bit.
   function automatic int clog2_w(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr,
// searching upward and wrapping past NUM_REQ-1 back to 0.
module rr_pick
   import fsm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = clog2_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [ID_W-1:0]    id,
   output logic               any
);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] sel;

   // Extra bit on sum keeps ptr+i from overflowing before the modulo fold,
   // which matters when NUM_REQ is not a power of two.
   always_comb begin
      onehot = '0;
      id     = '0;
      any    = 1'b0;
      sum    = '0;
      sel    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         sel = sum[ID_W-1:0];
         if (!any && req[sel]) begin
            any         = 1'b1;
            onehot[sel] = 1'b1;
            id          = sel;
         end
      end
   end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter with bounded grant tenure; all outputs come straight from flops.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no owner; arbitrate from ptr every cycle
//   ST_GRANT | gnt_id owns the resource; hold_cnt counts its extra cycles
//   ST_GAP   | one dead cycle after a release/expiry; arbitrate from ptr
module fsm_rr_arbiter
   import fsm_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int MAX_HOLD = 8,
   localparam int ID_W     = clog2_w(NUM_REQ),
   localparam int CNT_W    = clog2_w(MAX_HOLD + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [ID_W-1:0]    gnt_id,
   output logic               timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);

   arb_state_t          state;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     ptr_next;
   logic [CNT_W-1:0]    hold_cnt;
   logic [NUM_REQ-1:0]  pick_onehot;
   logic [ID_W-1:0]     pick_id;
   logic                pick_any;
   logic                owner_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .id     (pick_id),
      .any    (pick_any)
   );

   assign owner_req = req[gnt_id];
   assign ptr_next  = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         timeout   <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE, ST_GAP: begin
               hold_cnt <= '0;
               if (pick_any) begin
                  state     <= ST_GRANT;
                  gnt       <= pick_onehot;
                  gnt_valid <= 1'b1;
                  gnt_id    <= pick_id;
               end else begin
                  state     <= ST_IDLE;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
               end
            end
            ST_GRANT: begin
               // Release is tested first so a drop on the last allowed cycle never flags timeout.
               if (!owner_req) begin
                  state     <= ST_GAP;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  ptr       <= ptr_next;
               end else if (hold_cnt == HOLD_LAST) begin
                  state     <= ST_GAP;
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  ptr       <= ptr_next;
                  timeout   <= 1'b1;
               end else begin
                  hold_cnt  <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               gnt       <= '0;
               gnt_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Bench for fsm_rr_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a tenure/queue-level model.
module tb_fsm_rr_arbiter;

   localparam int N  = 4;
   localparam int MH = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_id;
   logic         timeout;

   int n_pass  = 0;
   int n_total = 0;
   bit check_en = 1'b0;

   // Model: who owns the resource, how many cycles it has been visible, next search start.
   int m_owner = -1;
   int m_ten   = 0;
   int m_ptr   = 0;
   int m_last  = 0;
   bit m_to    = 1'b0;

   always #5 clock = ~clock;

   fsm_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
   endtask

   always @(posedge clock) begin
      if (reset) begin
         m_owner = -1;
         m_ten   = 0;
         m_ptr   = 0;
         m_last  = 0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner >= 0) begin
            if (req[2'(m_owner)] == 1'b0 || m_ten == MH) begin
               m_to    = (req[2'(m_owner)] == 1'b1);
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end else begin
               m_ten++;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               int a;
               a = (m_ptr + k) % N;
               if (m_owner < 0 && req[2'(a)] == 1'b1) begin
                  m_owner = a;
                  m_last  = a;
                  m_ten   = 1;
               end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         check("model gnt", 32'(gnt), (m_owner >= 0) ? (32'(1) << m_owner) : 32'(0));
         check("model gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         check("model gnt_id", 32'(gnt_id), 32'(m_last));
         check("model timeout", 32'(timeout), 32'(m_to));
         check("timeout with grant", 32'(timeout & gnt_valid), 32'(0));
      end
   end

   initial begin
      reset = 1'b1;
      req   = 4'b1111;
      @(posedge clock);
      check_en = 1'b1;

      // Reset held with all requests pending.
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         check("reset gnt", 32'(gnt), 32'(0));
         check("reset gnt_valid", 32'(gnt_valid), 32'(0));
         check("reset timeout", 32'(timeout), 32'(0));
      end
      reset = 1'b0;
      @(negedge clock);
      check("first grant", 32'(gnt), 32'h1);

      // Saturation: 8-cycle tenures, each followed by a timeout gap.
      for (int a = 0; a < 5; a++) begin
         for (int c = 1; c <= MH; c++) begin
            if (c == 1 || c == MH) check("sat gnt", 32'(gnt), 32'(1) << (a % N));
            @(negedge clock);
         end
         check("sat gap gnt", 32'(gnt), 32'(0));
         check("sat gap timeout", 32'(timeout), 32'(1));
         @(negedge clock);
      end

      reset = 1'b1;
      req   = 4'b0000;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Single agent, requesting in cycles 0..3.
      req = 4'b0001;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         check("single gnt", 32'(gnt), 32'h1);
         check("single gnt_id", 32'(gnt_id), 32'(0));
         if (c == 4) req = 4'b0000;
      end
      @(negedge clock);
      check("single release gnt", 32'(gnt), 32'(0));
      check("single release timeout", 32'(timeout), 32'(0));

      // Wrap: agent 2 releases, leaving ptr at 3; agent 0 must win over agent 2.
      req = 4'b0100;
      @(negedge clock);
      check("wrap setup gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      @(negedge clock);
      check("wrap gap gnt", 32'(gnt), 32'(0));
      req = 4'b0101;
      @(negedge clock);
      check("wrap gnt", 32'(gnt), 32'h1);

      // Owner drops in its last allowed cycle: release, not timeout.
      for (int c = 2; c <= MH; c++) begin
         @(negedge clock);
         if (c == MH) req = 4'b0100;
      end
      @(negedge clock);
      check("rel-vs-exp gnt", 32'(gnt), 32'(0));
      check("rel-vs-exp timeout", 32'(timeout), 32'(0));
      @(negedge clock);
      check("rel-vs-exp next owner", 32'(gnt), 32'h4);

      // Reset in the third cycle of agent 2's grant.
      req = 4'b0101;
      @(negedge clock);
      @(negedge clock);
      check("midgrant before reset", 32'(gnt), 32'h4);
      reset = 1'b1;
      @(negedge clock);
      check("midgrant reset gnt", 32'(gnt), 32'(0));
      check("midgrant reset timeout", 32'(timeout), 32'(0));
      reset = 1'b0;
      @(negedge clock);
      check("post-reset ptr0 gnt", 32'(gnt), 32'h1);

      // Random requests that persist for a while, with rare resets.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] r;
         r = req;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         end
         req   = r;
         reset = ($urandom_range(0, 299) == 0);
         @(negedge clock);
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
